// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Opcodes, instruction formats, immediate range limits and the stage-1 field payload.
package instr_enc_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned F7_W     = 7;
  localparam int unsigned IMM_W    = 32;
  localparam int unsigned ERRCNT_W = 16;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  // Signed limits of the immediates each format can carry
  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -(1 << 20);
  localparam int IMM_J_MAX = (1 << 20) - 2;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
    logic [IMM_W-1:0] imm;
  } fields_t;

  function automatic fmt_e fmt_of(input logic [OPC_W-1:0] opcode);
    fmt_e fmt;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
      OP_STORE:                 fmt = FMT_S;
      OP_BRANCH:                fmt = FMT_B;
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      OP_JAL:                   fmt = FMT_J;
      OP_REG:                   fmt = FMT_R;
      default:                  fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instr_enc_pack.sv
// Combinational RV32I field packer with immediate range/alignment check.
// Out-of-range immediates are still packed bit-truncated; unknown opcodes yield 0.
import instr_enc_pkg::*;

module instr_enc_pack (
  input  fields_t             fields,
  output logic [INSTR_W-1:0]  instr_c,
  output logic                err_c
);

  fmt_e                    fmt;
  logic signed [IMM_W-1:0] simm;
  logic                    fits_i;
  logic                    fits_b;
  logic                    fits_j;
  logic                    odd;

  assign fmt    = fmt_of(fields.opcode);
  assign simm   = $signed(fields.imm);
  assign fits_i = (simm >= IMM_I_MIN) && (simm <= IMM_I_MAX);
  assign fits_b = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX);
  assign fits_j = (simm >= IMM_J_MIN) && (simm <= IMM_J_MAX);
  assign odd    = fields.imm[0];

  always_comb begin
    instr_c = '0;
    err_c   = 1'b0;
    case (fmt)
      FMT_R: begin
        instr_c = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                   fields.rd, fields.opcode};
      end
      FMT_I: begin
        instr_c = {fields.imm[11:0], fields.rs1, fields.funct3,
                   fields.rd, fields.opcode};
        err_c   = !fits_i;
      end
      FMT_S: begin
        instr_c = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                   fields.imm[4:0], fields.opcode};
        err_c   = !fits_i;
      end
      FMT_B: begin
        instr_c = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                   fields.funct3, fields.imm[4:1], fields.imm[11], fields.opcode};
        err_c   = !fits_b || odd;
      end
      FMT_U: begin
        instr_c = {fields.imm[31:12], fields.rd, fields.opcode};
        err_c   = |fields.imm[11:0];
      end
      FMT_J: begin
        instr_c = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                   fields.imm[19:12], fields.rd, fields.opcode};
        err_c   = !fits_j || odd;
      end
      default: begin
        instr_c = '0;
        err_c   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with running word-address counter.
// Optional build macro INSTR_ENC_ERRCNT_EN adds a saturating err_count output.
import instr_enc_pkg::*;

module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  input  logic [F3_W-1:0]     funct3,
  input  logic [F7_W-1:0]     funct7,
  input  logic [IMM_W-1:0]    imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err
`ifdef INSTR_ENC_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  fields_t              s1_fields_q, s1_fields_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [INSTR_W-1:0]   s2_instr_q, s2_instr_d;
  logic                 s2_err_q, s2_err_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;

  logic                 s2_load;
  logic                 in_hs;
  logic                 out_hs;
  logic [INSTR_W-1:0]   pack_instr;
  logic                 pack_err;

  // A stage loads when empty or when the stage after it is draining
  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = s2_valid_q && out_ready;

  instr_enc_pack u_pack (
    .fields  (s1_fields_q),
    .instr_c (pack_instr),
    .err_c   (pack_err)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_fields_d = s1_fields_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_hs) begin
      s1_fields_d.opcode = opcode;
      s1_fields_d.rd     = rd;
      s1_fields_d.rs1    = rs1;
      s1_fields_d.rs2    = rs2;
      s1_fields_d.funct3 = funct3;
      s1_fields_d.funct7 = funct7;
      s1_fields_d.imm    = imm;
    end
  end

  // Stage 2 holds its word while stalled so outputs stay stable
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = pack_instr;
        s2_err_d   = pack_err;
      end
    end
  end

  // clear beats a simultaneous handshake; the handshaking beat keeps the old address
  always_comb begin
    addr_d = addr_q;
    if (clear) begin
      addr_d = ADDR_W'(BASE_ADDR);
    end else if (out_hs) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_fields_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= '0;
      s2_err_q    <= 1'b0;
      addr_q      <= ADDR_W'(BASE_ADDR);
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fields_q <= s1_fields_d;
      s2_valid_q  <= s2_valid_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      addr_q      <= addr_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign out_addr  = addr_q;

`ifdef INSTR_ENC_ERRCNT_EN
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

  // Saturating count of accepted error beats
  always_comb begin
    errcnt_d = errcnt_q;
    if (clear) begin
      errcnt_d = '0;
    end else if (out_hs && s2_err_q && (errcnt_q != '1)) begin
      errcnt_d = errcnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign err_count = errcnt_q;
`endif

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate extraction: packs opcode, register fields, funct fields and a 32-bit immediate into a 32-bit RV32I instruction word.
- Checks that the immediate is representable in the target format.
- Two-stage valid/ready pipeline with a running word-address counter.
- Sits between the test-program loader / bench stimulus generator and instruction memory. Each output beat is a write of out_instr at out_addr.

Parameters:
- ADDR_W, 10, width of the output word-address counter; wraps at 2^ADDR_W.
- BASE_ADDR, 0, counter value after reset and after clear.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous; reload address counter to BASE_ADDR
- in_valid  in  1  input beat valid
- in_ready  out  1  encoder can accept a beat
- opcode  in  7  instruction opcode
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R-type only)
- imm  in  32  signed/byte immediate as the core sees it after extension
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address for out_instr
- out_err  out  1  immediate not representable, or opcode unsupported

Behaviour:
- Reset (async assert, sync release): all valid bits 0, counter = BASE_ADDR, out_instr = 0, out_err = 0.
- Stage 1 registers the raw fields. Stage 2 registers the encoded word and the error flag.
- Latency: 2 clk from input handshake to out_valid. Throughput: 1 beat/clk.
- Pipeline advance rule: each stage loads when it is empty or the stage after it is being drained. in_ready = !s1_valid || s2 loading.
- Backpressure must not drop or duplicate beats.
- out_* remain stable while out_valid && !out_ready.
- Encoding by opcode:
  - I-type (0000011, 0010011, 1100111): imm[11:0] goes to [31:20]. Legal range −2048..2047.
  - S-type (0100011): imm[11:5] goes to [31:25]; imm[4:0] goes to [11:7]. Legal range −2048..2047.
  - B-type (1100011): imm[12]→[31], imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→[7]. Legal range −4096..4094; imm[0] must be 0.
  - U-type (0110111, 0010111): imm[31:12] goes to [31:12]. imm[11:0] must be 0.
  - J-type (1101111): imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12]. Legal range −2^20..2^20−2; imm[0] must be 0.
  - R-type (0110011): funct7 goes to [31:25]; imm is ignored; never flags an error.
- Field placement: rd, funct3, rs1, rs2 are placed at their standard positions only where the format has them. Unused field bits are 0.
- Range or alignment violation: out_err = 1. out_instr still carries the truncated bit pattern (no clamping).
- Unsupported opcode: out_instr = 0, out_err = 1.
- Address counter: out_addr = counter. The counter increments by 1 on each out_valid && out_ready and wraps from 2^ADDR_W−1 to 0.
- clear in the same cycle as an output handshake: the beat uses the old address; next counter = BASE_ADDR (clear wins).
- clear does not flush the pipeline.
- rst_n asserted mid-stream: in-flight beats are discarded; out_valid drops immediately.

Optional Feature:
- Macro INSTR_ENC_ERRCNT_EN.
- Defined: adds output err_count (16 bits). It increments on each output handshake with out_err = 1 and saturates at 0xFFFF. It resets to 0 on rst_n or clear.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package instr_enc_pkg holds:
  - opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG);
  - a format enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD);
  - range limit constants.
- One sub-module, instr_enc_pack: purely combinational field packing plus range check. Stage 2 is a register around it.

Test Plan:
- ADDI x1, x0, 5 (opcode 0010011, rd=1, imm=5) → out_instr 0x00500093, out_err 0, out_addr 0, two cycles after the handshake.
- SW x2, 4(x3) (opcode 0100011, funct3=010, rs1=3, rs2=2, imm=4) → out_instr 0x0021A223.
- JAL x1, −4 (imm 0xFFFFFFFC) → out_instr 0xFFDFF0EF. BEQ x0, x0, +8 → out_instr 0x00000463. LUI x5 with imm 0x12345000 → out_instr 0x123452B7.
- ADDI x1 with imm 2048 → out_err 1, out_instr 0x80000093. BEQ with imm 3 → out_err 1. Opcode 1111111 → out_instr 0, out_err 1.
- Stream of 8 beats with out_ready toggling 1010…:
  - no loss or duplication;
  - outputs hold while stalled;
  - addresses 0..7 in order.
- ADDR_W=2, stream 5 beats → addresses 0,1,2,3,0. clear on the 3rd handshake → that beat uses addr 2, and the next beat gets BASE_ADDR.
